// File: rtl/ir_pkg.sv
// Shared definitions for the IR transmit scheduler: command width, owner ids,
// FSM state encodings and counter widths.
package ir_pkg;

  localparam int CMD_W   = 12;
  localparam int REP_W   = 8;
  localparam int TIMER_W = 24;

  localparam logic OWNER_AUTO = 1'b0;
  localparam logic OWNER_MAN  = 1'b1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY  = 2'd1;
  localparam logic [1:0] S_WAIT_FRAME = 2'd2;
  localparam logic [1:0] S_GAP        = 2'd3;

  typedef logic [CMD_W-1:0] cmd_t;

  // A repeat count of zero still sends one frame per grant.
  function automatic logic [REP_W-1:0] eff_repeat(input int unsigned rc);
    if (rc == 0) begin
      return REP_W'(1);
    end
    return REP_W'(rc);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request wins outright; on a tie the
// source that did not own the transmitter last time is chosen.
module rr_arbiter_2
  import ir_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  // reqs[0] is the auto source, reqs[1] the manual source.
  always_comb begin
    grant_valid = |reqs;
    grant_id    = OWNER_AUTO;
    if (reqs == 2'b11) begin
      grant_id = ~last_owner;
    end else if (reqs[1]) begin
      grant_id = OWNER_MAN;
    end
  end

endmodule

// File: rtl/ir_tx_scheduler.sv
// Shares the single IR transmitter between the auto and manual command sources,
// sending each granted command REPEAT_COUNT times with an idle gap between frames.
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int unsigned REPEAT_COUNT  = 3,
  parameter int unsigned GAP_CYCLES    = 5000000,
  parameter int unsigned START_TIMEOUT = 270000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             auto_req,
  input  logic [CMD_W-1:0] auto_cmd,
  output logic             auto_ack,
  output logic             auto_done,
  input  logic             man_req,
  input  logic [CMD_W-1:0] man_cmd,
  output logic             man_ack,
  output logic             man_done,
  output logic             tx_start,
  output logic [CMD_W-1:0] tx_data,
  input  logic             tx_busy,
  output logic             busy,
  output logic             owner,
  output logic             timeout_err
);

  localparam logic [REP_W-1:0]   REP_MAX  = eff_repeat(REPEAT_COUNT);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(START_TIMEOUT - 1);

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               last_owner_q, last_owner_d;
  logic               owner_q, owner_d;
  cmd_t               tx_data_q, tx_data_d;
  logic               auto_ack_q, auto_ack_d;
  logic               man_ack_q, man_ack_d;
  logic               auto_done_q, auto_done_d;
  logic               man_done_q, man_done_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_err_q, timeout_err_d;
  logic               busy_q, busy_d;

  logic grant_valid;
  logic grant_id;
  logic finish;

  rr_arbiter_2 u_arb (
    .reqs        ({man_req, auto_req}),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // The done cycle itself is spent in IDLE without granting, so a held request
  // is re-acked one full cycle after its done pulse.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rep_cnt_d     = rep_cnt_q;
    last_owner_d  = last_owner_q;
    owner_d       = owner_q;
    tx_data_d     = tx_data_q;
    timeout_err_d = timeout_err_q;
    auto_ack_d    = 1'b0;
    man_ack_d     = 1'b0;
    tx_start_d    = 1'b0;
    finish        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid && !(auto_done_q || man_done_q)) begin
          tx_data_d    = (grant_id == OWNER_MAN) ? man_cmd : auto_cmd;
          owner_d      = grant_id;
          last_owner_d = grant_id;
          auto_ack_d   = (grant_id == OWNER_AUTO);
          man_ack_d    = (grant_id == OWNER_MAN);
          tx_start_d   = 1'b1;
          rep_cnt_d    = '0;
          timer_d      = '0;
          state_d      = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_FRAME;
        end else if (timer_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          finish        = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_FRAME: begin
        if (!tx_busy) begin
          rep_cnt_d = rep_cnt_q + 1'b1;
          if (({1'b0, rep_cnt_q} + 9'd1) >= {1'b0, REP_MAX}) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = S_WAIT_BUSY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    auto_done_d = finish && (owner_q == OWNER_AUTO);
    man_done_d  = finish && (owner_q == OWNER_MAN);
    busy_d      = (state_d != S_IDLE);
  end

  // last_owner resets to manual so the auto source wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      rep_cnt_q     <= '0;
      last_owner_q  <= OWNER_MAN;
      owner_q       <= OWNER_AUTO;
      tx_data_q     <= '0;
      auto_ack_q    <= 1'b0;
      man_ack_q     <= 1'b0;
      auto_done_q   <= 1'b0;
      man_done_q    <= 1'b0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rep_cnt_q     <= rep_cnt_d;
      last_owner_q  <= last_owner_d;
      owner_q       <= owner_d;
      tx_data_q     <= tx_data_d;
      auto_ack_q    <= auto_ack_d;
      man_ack_q     <= man_ack_d;
      auto_done_q   <= auto_done_d;
      man_done_q    <= man_done_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign auto_ack    = auto_ack_q;
  assign man_ack     = man_ack_q;
  assign auto_done   = auto_done_q;
  assign man_done    = man_done_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Bench for ir_tx_scheduler: directed scenarios with random commands, checked against
// expected event times derived from the frame/gap/timeout rules.
module tb_ir_tx_scheduler;

  localparam int GAP    = 10;
  localparam int TMO    = 20;
  localparam int REP    = 3;
  localparam int FRAME  = 100;
  // Busy rises one cycle after a start and its fall is seen one cycle later.
  localparam int PERIOD = FRAME + GAP + 2;

  logic        clock;
  logic        reset;
  logic        auto_req, man_req;
  logic [11:0] auto_cmd, man_cmd;
  logic        auto_ack, auto_done, man_ack, man_done;
  logic        tx_start, tx_busy, busy, owner, timeout_err;
  logic [11:0] tx_data;

  logic        b_auto_req, b_man_req;
  logic [11:0] b_auto_cmd, b_man_cmd;
  logic        b_auto_ack, b_auto_done, b_man_ack, b_man_done;
  logic        b_tx_start, b_tx_busy, b_busy, b_owner, b_timeout_err;
  logic [11:0] b_tx_data;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  ir_tx_scheduler #(.REPEAT_COUNT(REP), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .auto_req(auto_req), .auto_cmd(auto_cmd), .auto_ack(auto_ack), .auto_done(auto_done),
    .man_req(man_req), .man_cmd(man_cmd), .man_ack(man_ack), .man_done(man_done),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  ir_tx_scheduler #(.REPEAT_COUNT(0), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut_b (
    .clock(clock), .reset(reset),
    .auto_req(b_auto_req), .auto_cmd(b_auto_cmd), .auto_ack(b_auto_ack), .auto_done(b_auto_done),
    .man_req(b_man_req), .man_cmd(b_man_cmd), .man_ack(b_man_ack), .man_done(b_man_done),
    .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_busy(b_tx_busy),
    .busy(b_busy), .owner(b_owner), .timeout_err(b_timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Transmitter models: busy from one cycle after a start, for FRAME cycles.
  int   busyCnt = 0;
  int   bBusyCnt = 0;
  logic txNever = 1'b0;

  always @(posedge clock) begin
    if (tx_start && !txNever) busyCnt <= FRAME;
    else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    if (b_tx_start) bBusyCnt <= FRAME;
    else if (bBusyCnt > 0) bBusyCnt <= bBusyCnt - 1;
  end
  assign tx_busy   = (busyCnt != 0);
  assign b_tx_busy = (bBusyCnt != 0);

  int          ackAutoQ[$], ackManQ[$], doneAutoQ[$], doneManQ[$], startQ[$];
  logic [11:0] startDataQ[$];
  logic        startOwnerQ[$];
  int          bAckQ[$], bDoneQ[$], bStartQ[$];
  logic        bAckOwnerQ[$], bDoneOwnerQ[$];
  logic [11:0] bStartDataQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (auto_ack)  ackAutoQ.push_back(cyc);
    if (man_ack)   ackManQ.push_back(cyc);
    if (auto_done) doneAutoQ.push_back(cyc);
    if (man_done)  doneManQ.push_back(cyc);
    if (tx_start) begin
      startQ.push_back(cyc);
      startDataQ.push_back(tx_data);
      startOwnerQ.push_back(owner);
    end
    if (b_auto_ack || b_man_ack) begin
      bAckQ.push_back(cyc);
      bAckOwnerQ.push_back(b_man_ack);
    end
    if (b_auto_done || b_man_done) begin
      bDoneQ.push_back(cyc);
      bDoneOwnerQ.push_back(b_man_done);
    end
    if (b_tx_start) begin
      bStartQ.push_back(cyc);
      bStartDataQ.push_back(b_tx_data);
    end
    checkOutput("done_exclusive", {31'b0, auto_done & man_done}, 32'd0);
    checkOutput("ack_exclusive", {31'b0, auto_ack & man_ack}, 32'd0);
    checkOutput("ack_with_done", {31'b0, (auto_ack | man_ack) & (auto_done | man_done)}, 32'd0);
  end

  function automatic int txnEnd(input int ackCyc, input int frames, input bit timedOut);
    if (timedOut) return ackCyc + TMO;
    return ackCyc + (frames - 1) * PERIOD + FRAME + 2;
  endfunction

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic aReq, input logic [11:0] aCmd,
                               input logic mReq, input logic [11:0] mCmd);
    auto_req = aReq;
    auto_cmd = aCmd;
    man_req  = mReq;
    man_cmd  = mCmd;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_outs"},
                {12'b0, busy, owner, tx_start, auto_ack, man_ack, auto_done, man_done,
                 timeout_err, tx_data}, 32'd0);
    checkOutput({tag, "_b_outs"},
                {12'b0, b_busy, b_owner, b_tx_start, b_auto_ack, b_man_ack, b_auto_done,
                 b_man_done, b_timeout_err, b_tx_data}, 32'd0);
  endtask

  // Called at a negedge; reset is sampled by exactly one rising edge.
  task automatic applyReset(input string tag);
    reset = 1'b1;
    @(negedge clock);
    checkResetState(tag);
    reset = 1'b0;
  endtask

  task automatic checkTxn(input string tag, input logic who, input int ackCyc,
                          input logic [11:0] cmd, input int frames, input bit timedOut,
                          input bit expectDone);
    int obs;
    obs = -1;
    if (who == 1'b0 && ackAutoQ.size() > 0) obs = ackAutoQ.pop_front();
    if (who == 1'b1 && ackManQ.size() > 0)  obs = ackManQ.pop_front();
    checkOutput({tag, "_ack_cycle"}, obs, ackCyc);
    for (int i = 0; i < frames; i++) begin
      obs = (startQ.size() > 0) ? startQ.pop_front() : -1;
      checkOutput({tag, "_start_cycle"}, obs, ackCyc + i * PERIOD);
      obs = -1;
      if (startDataQ.size() > 0) obs = int'(startDataQ.pop_front());
      checkOutput({tag, "_tx_data"}, obs, {20'b0, cmd});
      obs = -1;
      if (startOwnerQ.size() > 0) obs = int'(startOwnerQ.pop_front());
      checkOutput({tag, "_owner"}, obs, {31'b0, who});
    end
    if (expectDone) begin
      obs = -1;
      if (who == 1'b0 && doneAutoQ.size() > 0) obs = doneAutoQ.pop_front();
      if (who == 1'b1 && doneManQ.size() > 0)  obs = doneManQ.pop_front();
      checkOutput({tag, "_done_cycle"}, obs, txnEnd(ackCyc, frames, timedOut));
    end
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_no_extra_events"},
                ackAutoQ.size() + ackManQ.size() + doneAutoQ.size() + doneManQ.size()
                + startQ.size(), 32'd0);
    ackAutoQ.delete(); ackManQ.delete(); doneAutoQ.delete(); doneManQ.delete();
    startQ.delete(); startDataQ.delete(); startOwnerQ.delete();
  endtask

  initial begin
    int a1, a2, a3, d1, d2, d3, r, off;
    logic [11:0] c1, c2, c3, mc;

    reset = 1'b1;
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
    b_auto_req = 1'b0; b_man_req = 1'b0; b_auto_cmd = '0; b_man_cmd = '0;
    repeat (2) @(negedge clock);
    applyReset("reset");

    // 1: single auto request, three frames of 00A
    applyStimulus(1'b1, 12'h00A, 1'b0, 12'h000);
    a1 = cyc + 1;
    waitUntil(a1);
    auto_req = 1'b0;
    checkOutput("s1_busy_during", {31'b0, busy}, 32'd1);
    d1 = txnEnd(a1, REP, 1'b0);
    waitUntil(d1);
    checkOutput("s1_tx_data_held", {20'b0, tx_data}, 32'h00A);
    waitUntil(d1 + 3);
    checkTxn("s1", 1'b0, a1, 12'h00A, REP, 1'b0, 1'b1);
    checkOutput("s1_busy_after", {31'b0, busy}, 32'd0);
    checkDrained("s1");

    // 2: simultaneous held requests alternate owners, auto first after reset
    applyReset("s2_reset");
    c1 = 12'($urandom); mc = 12'($urandom); c3 = 12'($urandom);
    applyStimulus(1'b1, c1, 1'b1, mc);
    a1 = cyc + 1;
    waitUntil(a1);
    auto_cmd = c3;
    d1 = txnEnd(a1, REP, 1'b0);
    a2 = d1 + 2;
    d2 = txnEnd(a2, REP, 1'b0);
    a3 = d2 + 2;
    waitUntil(a3);
    auto_req = 1'b0;
    man_req  = 1'b0;
    d3 = txnEnd(a3, REP, 1'b0);
    waitUntil(d3 + 3);
    checkTxn("s2_auto1", 1'b0, a1, c1, REP, 1'b0, 1'b1);
    checkTxn("s2_man",   1'b1, a2, mc, REP, 1'b0, 1'b1);
    checkTxn("s2_auto2", 1'b0, a3, c3, REP, 1'b0, 1'b1);
    checkDrained("s2");

    // 3: manual request during an auto transaction waits for it
    applyReset("s3_reset");
    c1 = 12'($urandom); mc = 12'($urandom);
    applyStimulus(1'b1, c1, 1'b0, 12'h000);
    a1 = cyc + 1;
    waitUntil(a1);
    auto_req = 1'b0;
    off = int'($urandom_range(5, 300));
    waitUntil(a1 + off);
    man_cmd = mc;
    man_req = 1'b1;
    d1 = txnEnd(a1, REP, 1'b0);
    a2 = d1 + 2;
    waitUntil(a2);
    man_req = 1'b0;
    d2 = txnEnd(a2, REP, 1'b0);
    waitUntil(d2 + 3);
    checkTxn("s3_auto", 1'b0, a1, c1, REP, 1'b0, 1'b1);
    checkTxn("s3_man",  1'b1, a2, mc, REP, 1'b0, 1'b1);
    checkDrained("s3");

    // 4: transmitter never goes busy -> timeout, sticky error
    applyReset("s4_reset");
    txNever = 1'b1;
    c1 = 12'($urandom); mc = 12'($urandom);
    applyStimulus(1'b1, c1, 1'b0, 12'h000);
    a1 = cyc + 1;
    waitUntil(a1);
    auto_req = 1'b0;
    d1 = txnEnd(a1, 1, 1'b1);
    waitUntil(d1 - 1);
    checkOutput("s4_err_before", {31'b0, timeout_err}, 32'd0);
    waitUntil(d1);
    checkOutput("s4_err_set", {31'b0, timeout_err}, 32'd1);
    txNever = 1'b0;
    waitUntil(d1 + 3);
    checkOutput("s4_idle_after_timeout", {31'b0, busy}, 32'd0);
    applyStimulus(1'b0, c1, 1'b1, mc);
    a2 = cyc + 1;
    waitUntil(a2);
    man_req = 1'b0;
    d2 = txnEnd(a2, REP, 1'b0);
    waitUntil(d2 + 3);
    checkTxn("s4_timeout", 1'b0, a1, c1, 1, 1'b1, 1'b1);
    checkTxn("s4_man", 1'b1, a2, mc, REP, 1'b0, 1'b1);
    checkOutput("s4_err_sticky", {31'b0, timeout_err}, 32'd1);
    checkDrained("s4");

    // 5: reset inside the gap after the second frame
    applyReset("s5_reset");
    c1 = 12'($urandom); c2 = 12'($urandom);
    applyStimulus(1'b1, c1, 1'b0, 12'h000);
    a1 = cyc + 1;
    waitUntil(a1);
    auto_cmd = c2;
    r = a1 + PERIOD + FRAME + 2 + 3;
    waitUntil(r);
    checkOutput("s5_in_gap_busy", {31'b0, busy}, 32'd1);
    applyReset("s5_mid_reset");
    a2 = cyc + 1;
    waitUntil(a2);
    auto_req = 1'b0;
    d2 = txnEnd(a2, REP, 1'b0);
    waitUntil(d2 + 3);
    checkTxn("s5_aborted", 1'b0, a1, c1, 2, 1'b0, 1'b0);
    checkTxn("s5_regrant", 1'b0, a2, c2, REP, 1'b0, 1'b1);
    checkDrained("s5");

    // 6: REPEAT_COUNT=0 instance sends one frame per grant
    applyReset("s6_reset");
    c1 = 12'($urandom); mc = 12'($urandom);
    b_auto_cmd = c1;
    b_auto_req = 1'b1;
    a1 = cyc + 1;
    waitUntil(a1);
    b_auto_req = 1'b0;
    d1 = a1 + FRAME + 2;
    waitUntil(d1 + 1);
    b_man_cmd = mc;
    b_man_req = 1'b1;
    a2 = d1 + 2;
    waitUntil(a2);
    b_man_req = 1'b0;
    d2 = a2 + FRAME + 2;
    waitUntil(d2 + PERIOD);
    checkOutput("s6_ack_count", bAckQ.size(), 32'd2);
    checkOutput("s6_start_count", bStartQ.size(), 32'd2);
    checkOutput("s6_done_count", bDoneQ.size(), 32'd2);
    if (bAckQ.size() == 2 && bStartQ.size() == 2 && bDoneQ.size() == 2) begin
      checkOutput("s6_ack1", bAckQ[0], a1);
      checkOutput("s6_ack1_owner", {31'b0, bAckOwnerQ[0]}, 32'd0);
      checkOutput("s6_start1", bStartQ[0], a1);
      checkOutput("s6_data1", {20'b0, bStartDataQ[0]}, {20'b0, c1});
      checkOutput("s6_done1", bDoneQ[0], d1);
      checkOutput("s6_done1_owner", {31'b0, bDoneOwnerQ[0]}, 32'd0);
      checkOutput("s6_ack2", bAckQ[1], a2);
      checkOutput("s6_ack2_owner", {31'b0, bAckOwnerQ[1]}, 32'd1);
      checkOutput("s6_start2", bStartQ[1], a2);
      checkOutput("s6_data2", {20'b0, bStartDataQ[1]}, {20'b0, mc});
      checkOutput("s6_done2", bDoneQ[1], d2);
      checkOutput("s6_done2_owner", {31'b0, bDoneOwnerQ[1]}, 32'd1);
    end
    checkOutput("s6_busy_after", {31'b0, b_busy}, 32'd0);
    checkDrained("s6_main_dut");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
